mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//   Memory stage directly downstream of the ALU. Consumes the ALU result Y as
//   either a writeback value or a data-memory address (ALUop ADDR_ADD path).
//   Runs load/store transactions over a req/ack data-memory port and presents
//   one writeback beat per load or non-memory op on a valid/ready interface.
//   Holds one operation at a time; no internal queue.
// PARAMETERS
//   DATA_W   32  data and address width
//   RD_W     5   destination-register index width
//   TIMEOUT  16  REQ cycles without dmem_ack before the transaction aborts (>=1)
// PORTS
//   clk            in   1       single clock, rising edge
//   rst_n          in   1       asynchronous, active-low reset
//   in_valid       in   1       upstream op valid
//   in_ready       out  1       stage can accept an op
//   in_op          in   2       0=NONE (pass Y), 1=LOAD, 2=STORE, 3=reserved (as NONE)
//   in_alu_y       in   DATA_W  ALU result: value (NONE) or byte address (LOAD/STORE)
//   in_store_data  in   DATA_W  store data
//   in_rd          in   RD_W    destination register
//   dmem_req       out  1       memory request, held until ack or timeout
//   dmem_we        out  1       1=write; valid while dmem_req
//   dmem_addr      out  DATA_W  word-aligned address; valid while dmem_req
//   dmem_wdata     out  DATA_W  write data; valid while dmem_req
//   dmem_rdata     in   DATA_W  read data, sampled on the ack cycle
//   dmem_ack       in   1       memory completion, 1-cycle pulse
//   wb_valid       out  1       writeback beat valid
//   wb_ready       in   1       writeback consumer ready
//   wb_data        out  DATA_W  writeback value
//   wb_rd          out  RD_W    writeback register
//   wb_we          out  1       register write enable (0 when wb_rd==0 or on error)
//   err_misalign   out  1       1-cycle pulse: LOAD/STORE address[1:0]!=0
//   err_timeout    out  1       1-cycle pulse: TIMEOUT cycles elapsed without ack
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; all outputs 0 except in_ready=1; timer=0.
//   Reset mid-transaction drops dmem_req and wb_valid immediately; op is lost.
//   FSM states: IDLE, REQ, WB.
//   in_ready = (state==IDLE). Accept on in_valid&&in_ready; all inputs registered.
//   IDLE, accept NONE/reserved -> WB: wb_data=in_alu_y, wb_we=(in_rd!=0).
//   IDLE, accept LOAD/STORE, addr[1:0]!=0 -> no request; err_misalign pulses next
//     cycle; LOAD -> WB with wb_data=0, wb_we=0; STORE -> stays IDLE.
//   IDLE, accept LOAD/STORE aligned -> REQ: dmem_req=1, dmem_we=(op==STORE),
//     addr/wdata stable until leaving REQ; timer cleared to 0.
//   REQ: dmem_ack sampled each cycle; ack on first REQ cycle is legal.
//     ack & LOAD  -> WB, wb_data=dmem_rdata, wb_we=(rd!=0); dmem_req drops.
//     ack & STORE -> IDLE, no wb beat.
//     no ack: timer++; when timer==TIMEOUT-1 without ack -> IDLE, err_timeout
//       pulses next cycle, no wb beat (loads discarded).
//   dmem_ack outside REQ is ignored.
//   WB: wb_valid=1, wb_* stable until wb_valid&&wb_ready, then -> IDLE.
//     No new op accepted in the handshake cycle (in_ready rises next cycle).
//   Latency: NONE accepted in cycle 0 -> wb_valid in cycle 1. LOAD accepted in
//     cycle 0 -> dmem_req cycle 1; ack in cycle k -> wb_valid cycle k+1.
//   Throughput: one op per (2 + memory wait) cycles minimum; NONE ops every
//     2 cycles with wb_ready tied high.
//   Address passed unmodified; no arithmetic on data; widths fixed at DATA_W.
// TESTING
//   Reset: rst_n=0 mid-REQ -> dmem_req=0, wb_valid=0, in_ready=1 same cycle.
//   NONE op Y=0x0000_002A, rd=3, wb_ready=1 -> cycle 1 wb_valid=1, data=0x2A,
//     wb_we=1; rd=0 variant -> wb_we=0.
//   LOAD addr=0x100, ack 3 cycles after req with rdata=0xDEADBEEF -> dmem_we=0,
//     addr=0x100 held; wb_data=0xDEADBEEF the cycle after ack.
//   STORE addr=0x204 data=0x1234_5678, ack on first REQ cycle -> one req cycle,
//     dmem_we=1, no wb_valid, in_ready=1 the next cycle.
//   Misaligned LOAD addr=0x102 -> no dmem_req, err_misalign pulse, wb beat
//     with wb_we=0; no ack ever, TIMEOUT=16 -> req held 16 cycles, err_timeout.
//   Backpressure: wb_ready=0 for 5 cycles -> wb_* stable, in_ready=0 throughout.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage behind the ALU: pass-through writeback, or load/store over a req/ack dmem port.
// Latency: NONE op 1 cycle to wb_valid; LOAD 1 cycle to dmem_req, wb_valid the cycle after dmem_ack.
// Backpressure: holds a single op; in_ready is low from accept until the op retires (wb handshake, store ack, error).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready, in_op,       upstream op handshake; op 0=NONE 1=LOAD 2=STORE 3=as NONE
//   in_alu_y, in_store_data, in_rd  ALU result (value or byte address), store data, destination register
//   dmem_req/we/addr/wdata          data-memory request, held until dmem_ack or timeout
//   dmem_rdata, dmem_ack            read data and 1-cycle completion pulse
//   wb_valid/wb_ready, wb_data,     writeback beat handshake and payload
//   wb_rd, wb_we
//   err_misalign, err_timeout       1-cycle error pulses
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_alu_y,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic              err_misalign,
    output logic              err_timeout
);

    // Timer counts REQ cycles 0..TIMEOUT-1; keep at least one bit for TIMEOUT==1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              we;
    } wb_beat_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    state_t     state, state_nxt;
    wb_beat_t   wb_q;
    mem_req_t   req_q;
    logic [TMR_W-1:0] timer;

    logic accept;
    logic in_is_mem;
    logic in_misal;
    logic timer_last;

    assign accept     = in_valid && in_ready;
    assign in_is_mem  = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign in_misal   = (in_alu_y[1:0] != 2'b00);
    assign timer_last = (timer == TMR_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded handshake outputs. Deriving these from
    // state alone makes an asynchronous reset drop req/valid immediately.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        dmem_req  = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!in_is_mem) begin
                        state_nxt = WB;
                    end else if (in_misal) begin
                        // Misaligned load still retires a (non-writing) beat;
                        // a misaligned store simply vanishes after the error.
                        state_nxt = (in_op == OP_LOAD) ? WB : IDLE;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    state_nxt = req_q.we ? IDLE : WB;
                end else if (timer_last) begin
                    state_nxt = IDLE;
                end
            end
            WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: operand capture, load return, timer, error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q         <= '0;
            req_q        <= '0;
            timer        <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_q.rd <= in_rd;
                        if (!in_is_mem) begin
                            wb_q.data <= in_alu_y;
                            wb_q.we   <= (in_rd != '0);
                        end else if (in_misal) begin
                            err_misalign <= 1'b1;
                            wb_q.data    <= '0;
                            wb_q.we      <= 1'b0;
                        end else begin
                            req_q.we    <= (in_op == OP_STORE);
                            req_q.addr  <= in_alu_y;
                            req_q.wdata <= in_store_data;
                            timer       <= '0;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        if (!req_q.we) begin
                            wb_q.data <= dmem_rdata;
                            wb_q.we   <= (wb_q.rd != '0);
                        end
                    end else if (timer_last) begin
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dmem_we    = req_q.we;
    assign dmem_addr  = req_q.addr;
    assign dmem_wdata = req_q.wdata;
    assign wb_data    = wb_q.data;
    assign wb_rd      = wb_q.rd;
    assign wb_we      = wb_q.we;

endmodule
